sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single 32-bit external asynchronous SRAM between two bus masters.
  - Port A: CPU general-purpose I/O bus.
  - Port B: secondary master, e.g. a tube DMA or debug loader.
- Sequences each granted access as a plain read, a full-word write, or a read-modify-write for partial byte enables.
- Drives the active-low SRAM strobes. The bidirectional data bus tri-state sits outside this block.

Parameters:
RD_LATENCY, 1, extra wait cycles (0..7) holding read strobes before data capture
WR_LATENCY, 1, extra wait cycles (0..7) holding write strobes before release
ADDR_W, 19, SRAM word address width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
a_req  input  1  port A request, level, held until a_ack
a_wr  input  1  port A 1=write 0=read
a_addr  input  ADDR_W  port A word address
a_be  input  4  port A byte enables, bit n = byte lane n
a_wdata  input  32  port A write data
a_rdata  output  32  port A read data, valid while a_ack=1
a_ack  output  1  port A completion pulse
b_req, b_wr, b_addr, b_be, b_wdata, b_rdata, b_ack: same as port A, for port B
ram_cs_b  output  1  SRAM chip select, active low
ram_oe_b  output  1  SRAM output enable, active low
ram_we_b  output  1  SRAM write enable, active low
ram_addr  output  ADDR_W  SRAM address
ram_wdata  output  32  data to drive onto the SRAM bus
ram_wdata_oe  output  1  1 = external tri-state drives ram_wdata
ram_rdata  input  32  SRAM bus as read back
busy  output  1  state != IDLE
grant_b  output  1  1 = current or last transaction belongs to port B

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=IDLE; ram_cs_b/oe_b/we_b=1; ram_wdata_oe=0.
  - ram_addr=0, ram_wdata=0, a_rdata=b_rdata=0, a_ack=b_ack=0, grant_b=0, lcount=0.
- Reset mid-operation: abandon the transaction immediately. No ack is issued; strobes go inactive on the same edge.
- States: IDLE, READ, RMW_RD, WRITE, DONE.
- Requests are sampled only in IDLE. At grant, the winning port's wr/addr/be/wdata are latched. The requester may change its inputs after grant.
- Arbitration in IDLE: when only one req is high, that port wins. When both are high, see Optional Feature.
- IDLE → READ (grant, read): cs_b=0, oe_b=0, we_b=1, wdata_oe=0, lcount=RD_LATENCY.
- IDLE → WRITE (grant, write, be=1111): cs_b=0, oe_b=1, we_b=0, wdata=latched wdata, wdata_oe=1, lcount=WR_LATENCY.
- IDLE → RMW_RD (grant, write, be partial and non-zero): read strobes as for READ, lcount=RD_LATENCY.
- IDLE → DONE (grant, write, be=0000): no SRAM strobes; ack asserted.
- READ:
  - While lcount != 0: decrement.
  - At 0: latch ram_rdata into the granted port's rdata, release strobes, assert ack, go to DONE.
- RMW_RD:
  - While lcount != 0: decrement.
  - At 0: ram_wdata = per-lane merge (be[n] ? latched wdata lane n : ram_rdata lane n); oe_b=1, we_b=0, wdata_oe=1, lcount=WR_LATENCY, go to WRITE.
- WRITE:
  - While lcount != 0: decrement.
  - At 0: release strobes, wdata_oe=0, assert ack, go to DONE.
- DONE: ack=0, go to IDLE.
- Ack and rdata timing:
  - Ack is high for exactly one cycle and only to the granted port.
  - rdata holds its value until the next read by that port.
- Latency from the IDLE grant edge E0 to the edge where ack rises:
  - Read: E0+RD_LATENCY+1.
  - Full write: E0+WR_LATENCY+1.
  - RMW: E0+RD_LATENCY+WR_LATENCY+2.
  - be=0000 write: E0+1.
- Requester rule: req must be low at the IDLE edge following DONE, otherwise it is treated as a new request.
- Minimum gap between back-to-back transactions is one IDLE cycle.
- ram_addr holds its last value when idle.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined: with both req high in IDLE, the port not served in the previous transaction wins. The last-served indicator resets to B, so A wins the first contention.
- Undefined: fixed priority, port A always wins contention. Port B can starve.

Test Plan:
- Read, RD_LATENCY=1: preload word 0x00012=0xDEADBEEF; a_req=1, a_wr=0, a_addr=0x12 → cs_b/oe_b low for 2 cycles; a_ack rises at E0+2; a_rdata=0xDEADBEEF; b_ack stays 0.
- RMW: word 0x00040=0x11223344; b write be=0101, wdata=0xAABBCCDD → SRAM written 0x11BB33DD; b_ack at E0+4; we_b low only in the WRITE phase.
- Full write and be=0000: a write be=1111, 0xCAFEF00D to 0x7FFFF (top address) → stored, ack at E0+2, no read strobe. be=0000 write → no strobes, ack at E0+1, memory unchanged.
- Contention, both req held through 3 transactions: fixed priority serves A,A,A. With SRAM_ARB_ROUND_ROBIN_EN: A,B,A; grant_b tracks the winner.
- Reset mid-RMW: rst=1 during RMW_RD → next edge all strobes=1, wdata_oe=0, no ack, state IDLE. SRAM word unchanged; a fresh request after reset completes normally.
- Held-req violation: keep a_req high after a_ack → exactly one extra transaction is started at the IDLE edge. Verifies sampling occurs only in IDLE and DONE is one cycle.

Source files
------------

// File: rtl/sram_arbiter.sv
// Purpose : shares one 32-bit async SRAM between port A (CPU I/O bus) and port B (DMA/loader);
//           sequences read, full-word write, or read-modify-write for partial byte enables.
// Latency : read RD_LATENCY+1, full write WR_LATENCY+1, RMW RD+WR+2, be=0000 write 1 (grant edge to ack edge).
// Backpressure: req is a level held until ack; requests are sampled only in IDLE, one IDLE cycle between accesses.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   a_*/b_*                  requester ports: req/wr/addr/be/wdata in, rdata/ack out
//   ram_cs_b/oe_b/we_b       active-low SRAM strobes
//   ram_addr, ram_wdata      SRAM address and write data (tri-state lives outside, enabled by ram_wdata_oe)
//   ram_rdata                SRAM data bus as read back
//   busy, grant_b            state != IDLE; current/last transaction belongs to port B
//
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for round-robin contention handling;
// undefined gives fixed priority with port A winning every contention.

module sram_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int WR_LATENCY = 1,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [3:0]        a_be,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [3:0]        b_be,
    input  logic [31:0]       b_wdata,
    output logic [31:0]       b_rdata,
    output logic              b_ack,
    output logic              ram_cs_b,
    output logic              ram_oe_b,
    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [31:0]       ram_rdata,
    output logic              busy,
    output logic              grant_b
);

    localparam logic [2:0] RD_LAT = 3'(RD_LATENCY);
    localparam logic [2:0] WR_LAT = 3'(WR_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          lcount_q, lcount_d;
    logic                cs_b_q, cs_b_d;
    logic                oe_b_q, oe_b_d;
    logic                we_b_q, we_b_d;
    logic                wdata_oe_q, wdata_oe_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic [31:0]         a_rdata_q, a_rdata_d;
    logic [31:0]         b_rdata_q, b_rdata_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic                grant_b_q, grant_b_d;
    logic [31:0]         wdata_q, wdata_d;     // requester write data latched at grant
    logic [3:0]          be_q, be_d;           // requester byte enables latched at grant
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic                last_b_q, last_b_d;   // port served by the previous transaction
`endif

    // Arbitration and selected-port request fields
    logic                pick_b;
    logic                any_req;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [3:0]          sel_be;
    logic [31:0]         sel_wdata;
    logic [31:0]         merged;

    always_comb begin
        any_req = a_req | b_req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        // Under contention the port that did not get the previous transaction wins
        pick_b  = b_req & (~a_req | ~last_b_q);
`else
        pick_b  = b_req & ~a_req;
`endif
        sel_wr    = pick_b ? b_wr    : a_wr;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_be    = pick_b ? b_be    : a_be;
        sel_wdata = pick_b ? b_wdata : a_wdata;
    end

    // Per-lane merge for the write half of a read-modify-write
    always_comb begin
        merged = ram_rdata;
        for (int n = 0; n < 4; n++) begin
            if (be_q[n]) begin
                merged[n*8 +: 8] = wdata_q[n*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lcount_d    = lcount_q;
        cs_b_d      = cs_b_q;
        oe_b_d      = oe_b_q;
        we_b_d      = we_b_q;
        wdata_oe_d  = wdata_oe_q;
        addr_d      = addr_q;
        ram_wdata_d = ram_wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        grant_b_d   = grant_b_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_b_d    = last_b_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_b_d = pick_b;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    last_b_d  = pick_b;
`endif
                    wdata_d   = sel_wdata;
                    be_d      = sel_be;
                    if (!sel_wr || (sel_be != 4'b0000 && sel_be != 4'b1111)) begin
                        // Plain read, or the read half of a partial write
                        state_d    = sel_wr ? S_RMW_RD : S_READ;
                        addr_d     = sel_addr;
                        cs_b_d     = 1'b0;
                        oe_b_d     = 1'b0;
                        we_b_d     = 1'b1;
                        wdata_oe_d = 1'b0;
                        lcount_d   = RD_LAT;
                    end else if (sel_be == 4'b1111) begin
                        state_d     = S_WRITE;
                        addr_d      = sel_addr;
                        cs_b_d      = 1'b0;
                        oe_b_d      = 1'b1;
                        we_b_d      = 1'b0;
                        ram_wdata_d = sel_wdata;
                        wdata_oe_d  = 1'b1;
                        lcount_d    = WR_LAT;
                    end else begin
                        // Empty write: pass through WRITE with no strobes and a zero
                        // count so the ack lands one edge after the grant.
                        state_d  = S_WRITE;
                        lcount_d = 3'd0;
                    end
                end
            end

            S_READ: begin
                if (lcount_q != 3'd0) begin
                    lcount_d = lcount_q - 3'd1;
                end else begin
                    if (grant_b_q) begin
                        b_rdata_d = ram_rdata;
                        b_ack_d   = 1'b1;
                    end else begin
                        a_rdata_d = ram_rdata;
                        a_ack_d   = 1'b1;
                    end
                    cs_b_d  = 1'b1;
                    oe_b_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_RMW_RD: begin
                if (lcount_q != 3'd0) begin
                    lcount_d = lcount_q - 3'd1;
                end else begin
                    // Chip select stays low across the read-to-write turnaround
                    ram_wdata_d = merged;
                    oe_b_d      = 1'b1;
                    we_b_d      = 1'b0;
                    wdata_oe_d  = 1'b1;
                    lcount_d    = WR_LAT;
                    state_d     = S_WRITE;
                end
            end

            S_WRITE: begin
                if (lcount_q != 3'd0) begin
                    lcount_d = lcount_q - 3'd1;
                end else begin
                    cs_b_d     = 1'b1;
                    we_b_d     = 1'b1;
                    wdata_oe_d = 1'b0;
                    a_ack_d    = ~grant_b_q;
                    b_ack_d    = grant_b_q;
                    state_d    = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lcount_q    <= 3'd0;
            cs_b_q      <= 1'b1;
            oe_b_q      <= 1'b1;
            we_b_q      <= 1'b1;
            wdata_oe_q  <= 1'b0;
            addr_q      <= '0;
            ram_wdata_q <= 32'h0;
            a_rdata_q   <= 32'h0;
            b_rdata_q   <= 32'h0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            grant_b_q   <= 1'b0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_b_q    <= 1'b1;   // so port A wins the first contention
`endif
        end else begin
            state_q     <= state_d;
            lcount_q    <= lcount_d;
            cs_b_q      <= cs_b_d;
            oe_b_q      <= oe_b_d;
            we_b_q      <= we_b_d;
            wdata_oe_q  <= wdata_oe_d;
            addr_q      <= addr_d;
            ram_wdata_q <= ram_wdata_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            grant_b_q   <= grant_b_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_b_q    <= last_b_d;
`endif
        end
    end

    assign ram_cs_b     = cs_b_q;
    assign ram_oe_b     = oe_b_q;
    assign ram_we_b     = we_b_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign ram_wdata_oe = wdata_oe_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign a_ack        = a_ack_q;
    assign b_ack        = b_ack_q;
    assign grant_b      = grant_b_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose : directed bench for sram_arbiter with a 256-word SRAM model (low 8 address bits).
// Latency : measures grant-to-ack edges, strobe cycles and memory contents per access.
// Backpressure: requests held as levels until ack, dropped one edge after ack.

module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_wr, b_req, b_wr;
    logic [18:0] a_addr, b_addr;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic        a_ack, b_ack;
    logic        ram_cs_b, ram_oe_b, ram_we_b, ram_wdata_oe;
    logic [18:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        busy, grant_b;

    always #5 clk = ~clk;

    sram_arbiter #(.RD_LATENCY(1), .WR_LATENCY(1), .ADDR_W(19)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .ram_cs_b(ram_cs_b), .ram_oe_b(ram_oe_b), .ram_we_b(ram_we_b),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe),
        .ram_rdata(ram_rdata), .busy(busy), .grant_b(grant_b)
    );

    // SRAM model: combinational read, write on each clock while write strobes are active
    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h0;
    logic [31:0] pl_dat = 32'h0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_dat;
        else if (!ram_cs_b && !ram_we_b && ram_wdata_oe) mem[ram_addr[7:0]] <= ram_wdata;
    end
    assign ram_rdata = (!ram_cs_b && !ram_oe_b) ? mem[ram_addr[7:0]] : 32'h0;

    // Activity monitor, sampled mid-cycle
    int cyc = 0;
    int n_rd = 0, n_wr = 0, n_ov = 0, n_aa = 0, n_ab = 0, n_gr = 0;
    int start_cyc = 0, ack_cyc = 0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!ram_cs_b && !ram_oe_b) n_rd++;
        if (!ram_cs_b && !ram_we_b) n_wr++;
        if (!ram_oe_b && !ram_we_b) n_ov++;
        if (a_ack) n_aa++;
        if (b_ack) n_ab++;
        if (a_ack || b_ack) ack_cyc = cyc;
        if (busy && !busy_prev) begin
            n_gr++;
            start_cyc = cyc;
        end
        busy_prev = busy;
    end

    int checks = 0;
    int errors = 0;
    int s_rd, s_wr, s_ov, s_aa, s_ab, s_gr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_rd = n_rd; s_wr = n_wr; s_ov = n_ov;
        s_aa = n_aa; s_ab = n_ab; s_gr = n_gr;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [31:0] dat);
        pl_addr = addr;
        pl_dat  = dat;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (a_ack || b_ack) seen = 1'b1;
        end
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    endtask

    // One complete transaction; called just after a rising edge with the bus idle.
    // Inputs are scrambled after the grant edge to prove the request was latched.
    task automatic run(input bit pb, input bit wr, input logic [18:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, input string tag);
        snap();
        if (pb) begin
            b_wr = wr; b_addr = addr; b_be = be; b_wdata = wd; b_req = 1'b1;
        end else begin
            a_wr = wr; a_addr = addr; a_be = be; a_wdata = wd; a_req = 1'b1;
        end
        @(posedge clk); #1;
        if (pb) begin
            b_addr = ~addr; b_be = ~be; b_wdata = ~wd;
        end else begin
            a_addr = ~addr; a_be = ~be; a_wdata = ~wd;
        end
        wait_ack(tag);
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] winners;
        logic [2:0] exp_win;
        int k;

        rst = 1'b1;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_be = 4'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_be = 4'h0; b_wdata = 32'h0;
        #1;
        preload(8'h12, 32'hDEADBEEF);
        preload(8'h40, 32'h11223344);
        preload(8'hFF, 32'h00000000);
        @(posedge clk); #1;

        // Reset state
        chk("rst_cs_b",     32'(ram_cs_b), 32'd1);
        chk("rst_oe_b",     32'(ram_oe_b), 32'd1);
        chk("rst_we_b",     32'(ram_we_b), 32'd1);
        chk("rst_wdata_oe", 32'(ram_wdata_oe), 32'd0);
        chk("rst_addr",     32'(ram_addr), 32'd0);
        chk("rst_wdata",    ram_wdata, 32'h0);
        chk("rst_a_rdata",  a_rdata, 32'h0);
        chk("rst_b_rdata",  b_rdata, 32'h0);
        chk("rst_a_ack",    32'(a_ack), 32'd0);
        chk("rst_b_ack",    32'(b_ack), 32'd0);
        chk("rst_grant_b",  32'(grant_b), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Port A read of 0x12
        run(1'b0, 1'b0, 19'h00012, 4'hF, 32'h0, "rd_a");
        chk("rd_a_rdata",   a_rdata, 32'hDEADBEEF);
        chk("rd_a_latency", 32'(ack_cyc - start_cyc), 32'd2);
        chk("rd_a_oe_cyc",  32'(n_rd - s_rd), 32'd2);
        chk("rd_a_we_cyc",  32'(n_wr - s_wr), 32'd0);
        chk("rd_a_a_acks",  32'(n_aa - s_aa), 32'd1);
        chk("rd_a_b_acks",  32'(n_ab - s_ab), 32'd0);
        chk("rd_a_grant_b", 32'(grant_b), 32'd0);

        // Port B read-modify-write, be=0101
        run(1'b1, 1'b1, 19'h00040, 4'b0101, 32'hAABBCCDD, "rmw_b");
        chk("rmw_b_mem",     mem[8'h40], 32'h11BB33DD);
        chk("rmw_b_latency", 32'(ack_cyc - start_cyc), 32'd4);
        chk("rmw_b_oe_cyc",  32'(n_rd - s_rd), 32'd2);
        chk("rmw_b_we_cyc",  32'(n_wr - s_wr), 32'd2);
        chk("rmw_b_overlap", 32'(n_ov - s_ov), 32'd0);
        chk("rmw_b_b_acks",  32'(n_ab - s_ab), 32'd1);
        chk("rmw_b_a_acks",  32'(n_aa - s_aa), 32'd0);
        chk("rmw_b_grant_b", 32'(grant_b), 32'd1);
        chk("rmw_b_rdata",   b_rdata, 32'h0);

        // Port A full write to the top address
        run(1'b0, 1'b1, 19'h7FFFF, 4'hF, 32'hCAFEF00D, "wr_a");
        chk("wr_a_mem",     mem[8'hFF], 32'hCAFEF00D);
        chk("wr_a_latency", 32'(ack_cyc - start_cyc), 32'd2);
        chk("wr_a_oe_cyc",  32'(n_rd - s_rd), 32'd0);
        chk("wr_a_we_cyc",  32'(n_wr - s_wr), 32'd2);
        chk("wr_a_addr",    32'(ram_addr), 32'h7FFFF);

        // Port A write with no byte enables
        run(1'b0, 1'b1, 19'h00012, 4'h0, 32'h55555555, "wr0_a");
        chk("wr0_a_latency", 32'(ack_cyc - start_cyc), 32'd1);
        chk("wr0_a_oe_cyc",  32'(n_rd - s_rd), 32'd0);
        chk("wr0_a_we_cyc",  32'(n_wr - s_wr), 32'd0);
        chk("wr0_a_mem",     mem[8'h12], 32'hDEADBEEF);
        chk("wr0_a_a_acks",  32'(n_aa - s_aa), 32'd1);

        // Port B reads the top word; port A rdata must hold
        run(1'b1, 1'b0, 19'h7FFFF, 4'hF, 32'h0, "rd_b");
        chk("rd_b_rdata",  b_rdata, 32'hCAFEF00D);
        chk("rd_b_a_hold", a_rdata, 32'hDEADBEEF);

        // Contention: both requests held across three transactions
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_win = 3'b010;
`else
        exp_win = 3'b000;
`endif
        winners = 3'b000;
        k = 0;
        a_wr = 1'b0; a_addr = 19'h00012; a_be = 4'hF;
        b_wr = 1'b0; b_addr = 19'h00040; b_be = 4'hF;
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 60 && k < 3; i++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                winners[k] = b_ack;
                chk("cont_grant_b", 32'(grant_b), 32'(b_ack));
                k++;
            end
        end
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("cont_count", 32'(k), 32'd3);
        chk("cont_order", 32'(winners), 32'(exp_win));

        // Reset during the read half of an RMW
        snap();
        a_wr = 1'b1; a_addr = 19'h00040; a_be = 4'b0011; a_wdata = 32'h99999999; a_req = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_busy", 32'(busy), 32'd1);
        chk("rstmid_oe_b", 32'(ram_oe_b), 32'd0);
        rst = 1'b1;
        a_req = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_cs_b",     32'(ram_cs_b), 32'd1);
        chk("rstmid_oe_b_off", 32'(ram_oe_b), 32'd1);
        chk("rstmid_we_b",     32'(ram_we_b), 32'd1);
        chk("rstmid_wdata_oe", 32'(ram_wdata_oe), 32'd0);
        chk("rstmid_idle",     32'(busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rstmid_no_ack",  32'((n_aa - s_aa) + (n_ab - s_ab)), 32'd0);
        chk("rstmid_no_wr",   32'(n_wr - s_wr), 32'd0);
        chk("rstmid_mem",     mem[8'h40], 32'h11BB33DD);
        chk("rstmid_a_rdata", a_rdata, 32'h0);

        run(1'b0, 1'b0, 19'h00040, 4'hF, 32'h0, "rd_after_rst");
        chk("rd_after_rst_rdata",   a_rdata, 32'h11BB33DD);
        chk("rd_after_rst_latency", 32'(ack_cyc - start_cyc), 32'd2);

        // Held request: a_req still high at the IDLE edge after DONE
        snap();
        a_wr = 1'b0; a_addr = 19'h00012; a_be = 4'hF; a_req = 1'b1;
        wait_ack("held1");
        @(posedge clk); #1;
        chk("held_idle_gap", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("held_regrant", 32'(busy), 32'd1);
        a_req = 1'b0;
        wait_ack("held2");
        repeat (4) @(posedge clk);
        #1;
        chk("held_grants", 32'(n_gr - s_gr), 32'd2);
        chk("held_acks",   32'(n_aa - s_aa), 32'd2);
        chk("held_rdata",  a_rdata, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
